// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB snoop and issue bundle for the ALU reservation station.
//   slave  : the reservation station (consumes dispatch/CDB, drives rs_full and ex_*)
//   master : the dispatcher / surrounding core (drives dispatch/CDB, observes rs_full and ex_*)
interface alu_rs_if #(
  parameter int TAG_W = 4
);
  // dispatch
  logic             disp_valid;
  logic [5:0]       disp_opt;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;
  logic             disp_qj_busy;
  logic             disp_qk_busy;
  logic [TAG_W-1:0] disp_qj;
  logic [TAG_W-1:0] disp_qk;
  logic [31:0]      disp_imm;
  logic [TAG_W-1:0] disp_dest;
  logic             rs_full;
  // common data buses
  logic             cdb1_ok;
  logic [TAG_W-1:0] cdb1_en;
  logic [31:0]      cdb1_val;
  logic             cdb2_ok;
  logic [TAG_W-1:0] cdb2_en;
  logic [31:0]      cdb2_val;
  // issue port
  logic             ex_ok;
  logic [5:0]       ex_opt;
  logic [31:0]      ex_rs1;
  logic [31:0]      ex_rs2;
  logic [31:0]      ex_imm;
  logic [TAG_W-1:0] ex_en;

  modport slave (
    input  disp_valid, disp_opt, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_imm, disp_dest,
           cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val,
    output rs_full, ex_ok, ex_opt, ex_rs1, ex_rs2, ex_imm, ex_en
  );

  modport master (
    output disp_valid, disp_opt, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_imm, disp_dest,
           cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val,
    input  rs_full, ex_ok, ex_opt, ex_rs1, ex_rs2, ex_imm, ex_en
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station + issue scheduler for the ALU.
//   clk_in   : clock (rising edge)
//   rst_in   : synchronous active-high reset
//   rdy_in   : run enable, low freezes all state and drops ex_ok
//   clear_in : mispredict flush, frees every entry
//   bus      : alu_rs_if.slave (dispatch, CDB1/CDB2 snoop, rs_full, ex_* issue port)
// Entries are allocated lowest-free-first and issued lowest-ready-first,
// one per cycle, into registered ex_* outputs.

// One reservation-station slot: holds a micro-op, snoops both CDBs for
// pending operands, and reports readiness from its registered state.
module alu_rs_entry #(
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             alloc,
  input  logic             issue,
  input  logic [5:0]       d_opt,
  input  logic [31:0]      d_vj,
  input  logic             d_qj_busy,
  input  logic [TAG_W-1:0] d_qj,
  input  logic [31:0]      d_vk,
  input  logic             d_qk_busy,
  input  logic [TAG_W-1:0] d_qk,
  input  logic [31:0]      d_imm,
  input  logic [TAG_W-1:0] d_dest,
  input  logic             cdb1_ok,
  input  logic [TAG_W-1:0] cdb1_en,
  input  logic [31:0]      cdb1_val,
  input  logic             cdb2_ok,
  input  logic [TAG_W-1:0] cdb2_en,
  input  logic [31:0]      cdb2_val,
  output logic             busy,
  output logic             ready,
  output logic [5:0]       opt,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [31:0]      imm,
  output logic [TAG_W-1:0] dest
);
  typedef struct packed {
    logic             busy;
    logic [5:0]       opt;
    logic [31:0]      vj;
    logic             qj_busy;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic             qk_busy;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
  } entry_t;

  entry_t q, src, nxt;

  // The snoop is applied on top of either the stored entry or the incoming
  // dispatch, so the same logic gives both the wakeup and the dispatch bypass.
  always_comb begin
    src = q;
    if (alloc) begin
      src.busy    = 1'b1;
      src.opt     = d_opt;
      src.vj      = d_vj;
      src.qj_busy = d_qj_busy;
      src.qj      = d_qj;
      src.vk      = d_vk;
      src.qk_busy = d_qk_busy;
      src.qk      = d_qk;
      src.imm     = d_imm;
      src.dest    = d_dest;
    end
    nxt = src;
    if (src.busy && src.qj_busy) begin
      if (cdb1_ok && cdb1_en == src.qj) begin
        nxt.vj = cdb1_val; nxt.qj_busy = 1'b0;
      end else if (cdb2_ok && cdb2_en == src.qj) begin
        nxt.vj = cdb2_val; nxt.qj_busy = 1'b0;
      end
    end
    if (src.busy && src.qk_busy) begin
      if (cdb1_ok && cdb1_en == src.qk) begin
        nxt.vk = cdb1_val; nxt.qk_busy = 1'b0;
      end else if (cdb2_ok && cdb2_en == src.qk) begin
        nxt.vk = cdb2_val; nxt.qk_busy = 1'b0;
      end
    end
    if (issue) nxt.busy = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)        q <= '0;
    else if (rdy_in) begin
      if (clear_in)    q.busy <= 1'b0;
      else             q <= nxt;
    end
  end

  assign busy  = q.busy;
  assign ready = q.busy & ~q.qj_busy & ~q.qk_busy;
  assign opt   = q.opt;
  assign vj    = q.vj;
  assign vk    = q.vk;
  assign imm   = q.imm;
  assign dest  = q.dest;
endmodule

module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  input  logic  clear_in,
  alu_rs_if.slave bus
);
  localparam logic [RS_SIZE-1:0] ONE = RS_SIZE'(1);

  logic [RS_SIZE-1:0]             busy, ready, free, alloc_sel, issue_sel;
  logic [RS_SIZE-1:0][5:0]        e_opt;
  logic [RS_SIZE-1:0][31:0]       e_vj, e_vk, e_imm;
  logic [RS_SIZE-1:0][TAG_W-1:0]  e_dest;

  logic [5:0]       iss_opt;
  logic [31:0]      iss_vj, iss_vk, iss_imm;
  logic [TAG_W-1:0] iss_dest;

  // rs_full comes from registered busy bits, so a slot issued this edge is
  // only reusable next cycle.
  assign free        = ~busy;
  assign bus.rs_full = &busy;
  // x & (~x + 1) isolates the lowest set bit: lowest-index priority.
  assign alloc_sel   = (bus.disp_valid && !bus.rs_full) ? (free & (~free + ONE)) : '0;
  assign issue_sel   = ready & (~ready + ONE);

  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
    alu_rs_entry #(.TAG_W(TAG_W)) u_ent (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .clear_in  (clear_in),
      .alloc     (alloc_sel[i]),
      .issue     (issue_sel[i]),
      .d_opt     (bus.disp_opt),
      .d_vj      (bus.disp_vj),
      .d_qj_busy (bus.disp_qj_busy),
      .d_qj      (bus.disp_qj),
      .d_vk      (bus.disp_vk),
      .d_qk_busy (bus.disp_qk_busy),
      .d_qk      (bus.disp_qk),
      .d_imm     (bus.disp_imm),
      .d_dest    (bus.disp_dest),
      .cdb1_ok   (bus.cdb1_ok),
      .cdb1_en   (bus.cdb1_en),
      .cdb1_val  (bus.cdb1_val),
      .cdb2_ok   (bus.cdb2_ok),
      .cdb2_en   (bus.cdb2_en),
      .cdb2_val  (bus.cdb2_val),
      .busy      (busy[i]),
      .ready     (ready[i]),
      .opt       (e_opt[i]),
      .vj        (e_vj[i]),
      .vk        (e_vk[i]),
      .imm       (e_imm[i]),
      .dest      (e_dest[i])
    );
  end

  // issue_sel is one-hot (or zero), so a plain select loop is a clean mux.
  always_comb begin
    iss_opt  = '0;
    iss_vj   = '0;
    iss_vk   = '0;
    iss_imm  = '0;
    iss_dest = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_sel[i]) begin
        iss_opt  = e_opt[i];
        iss_vj   = e_vj[i];
        iss_vk   = e_vk[i];
        iss_imm  = e_imm[i];
        iss_dest = e_dest[i];
      end
    end
  end

  // Freeze and flush both drop ex_ok so a result is never broadcast twice;
  // the operand registers simply hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.ex_ok  <= 1'b0;
      bus.ex_opt <= '0;
      bus.ex_rs1 <= '0;
      bus.ex_rs2 <= '0;
      bus.ex_imm <= '0;
      bus.ex_en  <= '0;
    end else if (!rdy_in || clear_in) begin
      bus.ex_ok  <= 1'b0;
    end else begin
      bus.ex_ok  <= |ready;
      if (|ready) begin
        bus.ex_opt <= iss_opt;
        bus.ex_rs1 <= iss_vj;
        bus.ex_rs2 <= iss_vk;
        bus.ex_imm <= iss_imm;
        bus.ex_en  <= iss_dest;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  localparam int TAG_W = 4;

  typedef struct {
    logic [TAG_W-1:0] en;
    logic [5:0]       opt;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_rs_if #(.TAG_W(TAG_W)) bus();

  alu_rs #(.RS_SIZE(8), .TAG_W(TAG_W)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .clear_in (clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ex_ok cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ex_ok === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(bus.ex_en), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_en",  32'(bus.ex_en),  32'(e.en));
        chk("sb_opt", 32'(bus.ex_opt), 32'(e.opt));
        chk("sb_rs1", bus.ex_rs1, e.rs1);
        chk("sb_rs2", bus.ex_rs2, e.rs2);
        chk("sb_imm", bus.ex_imm, e.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] opt, input logic [31:0] vj, input logic qjb,
                      input logic [TAG_W-1:0] qj, input logic [31:0] vk, input logic qkb,
                      input logic [TAG_W-1:0] qk, input logic [31:0] imm,
                      input logic [TAG_W-1:0] dest);
    bus.disp_valid = 1'b1;  bus.disp_opt = opt;
    bus.disp_vj = vj;       bus.disp_qj_busy = qjb; bus.disp_qj = qj;
    bus.disp_vk = vk;       bus.disp_qk_busy = qkb; bus.disp_qk = qk;
    bus.disp_imm = imm;     bus.disp_dest = dest;
  endtask

  task automatic push(input logic [TAG_W-1:0] en, input logic [5:0] opt,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    e.en = en; e.opt = opt; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    sb.push_back(e);
  endtask

  task automatic cdb(input logic ok1, input logic [TAG_W-1:0] en1, input logic [31:0] v1,
                     input logic ok2, input logic [TAG_W-1:0] en2, input logic [31:0] v2);
    bus.cdb1_ok = ok1; bus.cdb1_en = en1; bus.cdb1_val = v1;
    bus.cdb2_ok = ok2; bus.cdb2_en = en2; bus.cdb2_val = v2;
  endtask

  initial begin
    bus.disp_valid = 1'b0;
    disp(6'd0, 32'd0, 1'b0, '0, 32'd0, 1'b0, '0, 32'd0, '0);
    bus.disp_valid = 1'b0;
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);

    // Reset
    tick(); tick();
    chk("rst_ex_ok",   32'(bus.ex_ok),   32'd0);
    chk("rst_ex_opt",  32'(bus.ex_opt),  32'd0);
    chk("rst_ex_rs1",  bus.ex_rs1,       32'd0);
    chk("rst_ex_rs2",  bus.ex_rs2,       32'd0);
    chk("rst_ex_imm",  bus.ex_imm,       32'd0);
    chk("rst_ex_en",   32'(bus.ex_en),   32'd0);
    chk("rst_rs_full", 32'(bus.rs_full), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_ex_ok", 32'(bus.ex_ok), 32'd0);

    // Ready-operand ADD: issue valid two cycles after dispatch
    disp(6'd1, 32'd5, 1'b0, '0, 32'd7, 1'b0, '0, 32'h11, 4'd3);
    push(4'd3, 6'd1, 32'd5, 32'd7, 32'h11);
    tick();
    bus.disp_valid = 1'b0;
    chk("add_e0_ex_ok", 32'(bus.ex_ok), 32'd0);
    tick();
    chk("add_e1_ex_ok", 32'(bus.ex_ok), 32'd1);
    chk("add_alu_sum",  bus.ex_rs1 + bus.ex_rs2, 32'd12);
    tick();
    chk("add_one_cycle", 32'(bus.ex_ok), 32'd0);

    // CDB2 wakeup of a pending SUB
    disp(6'd2, 32'hDEAD, 1'b1, 4'd2, 32'd4, 1'b0, '0, 32'h22, 4'd5);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    chk("sub_wait_ex_ok", 32'(bus.ex_ok), 32'd0);
    cdb(1'b0, '0, 32'd0, 1'b1, 4'd2, 32'd10);
    push(4'd5, 6'd2, 32'd10, 32'd4, 32'h22);
    tick();
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    chk("wake_en_ex_ok", 32'(bus.ex_ok), 32'd0);
    tick();
    chk("wake_en1_ex_ok", 32'(bus.ex_ok), 32'd1);
    tick();

    // Same with rdy_in low during the broadcast: not captured, no issue
    disp(6'd2, 32'hDEAD, 1'b1, 4'd2, 32'd4, 1'b0, '0, 32'h33, 4'd6);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    rdy = 1'b0;
    cdb(1'b0, '0, 32'd0, 1'b1, 4'd2, 32'd10);
    tick();
    rdy = 1'b1;
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    tick(); tick(); tick();
    chk("frozen_no_issue", 32'(bus.ex_ok), 32'd0);
    // Both buses carry tag 2: cdb1 value wins
    cdb(1'b1, 4'd2, 32'd20, 1'b1, 4'd2, 32'd30);
    push(4'd6, 6'd2, 32'd20, 32'd4, 32'h33);
    tick();
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    tick();
    chk("cdb1_wins_ex_ok", 32'(bus.ex_ok), 32'd1);
    tick();

    // Dispatch bypass, cdb1 checked before cdb2
    disp(6'd3, 32'd1, 1'b0, '0, 32'hBEEF, 1'b1, 4'd4, 32'h44, 4'd7);
    cdb(1'b1, 4'd4, 32'd9, 1'b1, 4'd4, 32'd99);
    push(4'd7, 6'd3, 32'd1, 32'd9, 32'h44);
    tick();
    bus.disp_valid = 1'b0;
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    tick();
    chk("bypass_ex_ok", 32'(bus.ex_ok), 32'd1);
    tick();

    // Fill all 8 entries waiting on tag 1
    for (int i = 0; i < 8; i++) begin
      disp(6'd4, 32'd0, 1'b1, 4'd1, 32'(i), 1'b0, '0, 32'(100 + i), 4'(8 + i));
      tick();
    end
    chk("full_after_8", 32'(bus.rs_full), 32'd1);
    disp(6'd5, 32'd1, 1'b0, '0, 32'd1, 1'b0, '0, 32'd0, 4'd0);  // dropped
    tick();
    bus.disp_valid = 1'b0;
    chk("full_after_9th", 32'(bus.rs_full), 32'd1);
    cdb(1'b0, '0, 32'd0, 1'b1, 4'd1, 32'hAA);
    for (int i = 0; i < 8; i++) push(4'(8 + i), 6'd4, 32'hAA, 32'(i), 32'(100 + i));
    tick();
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    chk("full_wake_ex_ok", 32'(bus.ex_ok), 32'd0);
    chk("full_wake_full",  32'(bus.rs_full), 32'd1);
    tick();
    chk("full_first_issue", 32'(bus.ex_ok), 32'd1);
    chk("full_drops",       32'(bus.rs_full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("full_burst_ex_ok", 32'(bus.ex_ok), 32'd1);
    end
    tick();
    chk("full_burst_end", 32'(bus.ex_ok), 32'd0);

    // Flush during the second issue cycle
    disp(6'd6, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, '0, 32'd0, 4'd10);
    tick();
    disp(6'd7, 32'd1, 1'b0, '0, 32'd1, 1'b0, '0, 32'd0, 4'd1);
    push(4'd1, 6'd7, 32'd1, 32'd1, 32'd0);
    tick();
    disp(6'd7, 32'd2, 1'b0, '0, 32'd2, 1'b0, '0, 32'd0, 4'd2);
    push(4'd2, 6'd7, 32'd2, 32'd2, 32'd0);
    tick();
    chk("flush_issue1", 32'(bus.ex_ok), 32'd1);
    disp(6'd7, 32'd3, 1'b0, '0, 32'd3, 1'b0, '0, 32'd0, 4'd3);
    tick();
    chk("flush_issue2", 32'(bus.ex_ok), 32'd1);
    clr = 1'b1;
    disp(6'd7, 32'd4, 1'b0, '0, 32'd4, 1'b0, '0, 32'd0, 4'd4);  // dropped by flush
    tick();
    clr = 1'b0;
    bus.disp_valid = 1'b0;
    chk("flush_ex_ok",   32'(bus.ex_ok),   32'd0);
    chk("flush_rs_full", 32'(bus.rs_full), 32'd0);
    cdb(1'b1, 4'd9, 32'd5, 1'b1, 4'd9, 32'd6);
    tick();
    cdb(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_flush_ex_ok", 32'(bus.ex_ok), 32'd0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the ALU execution unit in the Tomasulo core. It buffers up to `RS_SIZE` dispatched ALU/branch-compare micro-ops and captures missing operands by snooping both common data buses. Each cycle it selects one operand-complete entry and drives the combinational ALU through a registered issue port. The ALU result then appears on CDB 1 in the same cycle the issue port is valid.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, minimum 2.
- `TAG_W`, 4: ROB tag width; matches the ALU `en` field.
- `clk_in` input 1: clock; all state updates on the rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: global run enable; low means freeze.
- `clear_in` input 1: flush on mispredict.
- `disp_valid` input 1: dispatch request.
- `disp_opt` input 6: ALU opcode.
- `disp_vj` / `disp_vk` input 32: operand values; valid only when the matching busy bit is 0.
- `disp_qj_busy` / `disp_qk_busy` input 1: operand still pending.
- `disp_qj` / `disp_qk` input TAG_W: producer tag for a pending operand.
- `disp_imm` input 32: immediate.
- `disp_dest` input TAG_W: destination ROB tag.
- `rs_full` output 1: all entries busy.
- `cdb1_ok`, `cdb1_en[TAG_W]`, `cdb1_val[32]` input: ALU broadcast.
- `cdb2_ok`, `cdb2_en[TAG_W]`, `cdb2_val[32]` input: load/store broadcast.
- `ex_ok` output 1: issue valid.
- `ex_opt` output 6, `ex_rs1` output 32, `ex_rs2` output 32, `ex_imm` output 32, `ex_en` output TAG_W: issued operands.

## Operation
- **Entry fields:** busy, opt, vj, qj_busy, qj, vk, qk_busy, qk, imm, dest.
- **Ready condition:** an entry is ready when busy=1, qj_busy=0 and qk_busy=0. Readiness is computed from registered state only.
- **Allocation:**
  - When disp_valid=1 and rs_full=0, the lowest-index free entry is written.
  - When rs_full=1, dispatch is silently dropped. The dispatcher must not assert disp_valid while full.
- **Dispatch bypass:**
  - A pending dispatch operand whose tag equals a CDB tag broadcast in the same cycle is stored with busy=0 and the broadcast value.
  - cdb1 is checked before cdb2.
- **Snoop:**
  - For every busy entry, a pending operand whose tag matches cdb1_en (cdb1_ok=1) or cdb2_en (cdb2_ok=1) captures the value and clears its busy bit.
  - If both buses carry the same tag, cdb1 wins.
- **Selection:**
  - Each edge, the lowest-index ready entry is issued.
  - The issue registers load opt, vj, vk, imm and dest, and ex_ok is set to 1.
  - The entry's busy bit is cleared at the same edge.
  - With no ready entry, ex_ok is 0 and the other ex_* outputs hold their previous values.
- **Same-edge freeing:** an entry issued at edge E is available for allocation only from the cycle after E, because rs_full uses registered busy bits.
- **Priority per edge:** rst_in, then rdy_in=0, then clear_in, then normal operation.
  - rdy_in=0: every entry and every operand field holds, and ex_ok is set to 0 so no result is broadcast twice. CDB and dispatch inputs are ignored.
  - clear_in=1: all busy bits are cleared, ex_ok is set to 0, and dispatch in that cycle is dropped.
- **Reset:** all busy bits are 0 and every output is 0, including ex_* and rs_full.

## Timing
- Dispatch is sampled at edge E0. An operand-complete entry issues at E1, so ex_ok is high in the cycle after E1.
- Total latency is 2 cycles from the dispatch cycle to the issue-valid cycle.
- A broadcast at edge En completes an entry, which can issue at En+1 at the earliest.
- Throughput is one issue per cycle.
- ex_ok is high for exactly one cycle per issued entry.
- rs_full is combinational from the registered busy bits.
- Flush latency is 1 cycle: in the cycle after clear_in is sampled, ex_ok=0 and rs_full=0.

## Test plan
- **Reset:** assert rst_in for 2 cycles → ex_ok=0, every ex_* output=0, rs_full=0. An idle run with rdy_in=1 keeps ex_ok=0.
- **Ready-operand issue:** dispatch ADD with vj=5, vk=7, both busy=0, dest=3 → two cycles later ex_ok=1, ex_rs1=5, ex_rs2=7, ex_en=3 for one cycle. ALU CDB_1_val=12.
- **CDB wakeup:** dispatch SUB with qj_busy=1, qj=2, vk=4, dest=5. Two cycles later drive cdb2_ok=1, cdb2_en=2, cdb2_val=10 → ex_ok=1 on the second cycle after the broadcast, with ex_rs1=10, ex_rs2=4, ex_en=5. Same sequence with rdy_in=0 during the broadcast → value not captured and no issue.
- **Dispatch bypass:** dispatch with qk_busy=1, qk=4 while cdb1_ok=1, cdb1_en=4, cdb1_val=9 → issues with ex_rs2=9.
- **Full and in-order wakeup:** fill 8 entries, all waiting on tag 1 with dest 8..15 → rs_full=1 and a 9th dispatch is dropped. Broadcast cdb2 en=1, val=0xAA → 8 consecutive ex_ok cycles with ex_en=8,9,...,15 in index order. rs_full drops after the first issue.
- **Flush mid-operation:** with 3 ready entries, assert clear_in during the second issue cycle → ex_ok=0 and rs_full=0 from the next cycle. No further ex_ok occurs, even after matching broadcasts.
